bubble_output_sequencer: RTL and testbench
==========================================

// Module: bubble_output_sequencer
// PURPOSE
// - Drives the bubble buffer read side: generates ACCTYPE, BOUTCYCLENUM and BOUTTICKS for one access.
// - An access is either the bootloader stream or one user page.
// - Before streaming a page it requests a buffer load from the page loader and waits for the acknowledge.
// - Sits between the emulator front end (access requests) and the bubble buffer/loader pair.
// PARAMETERS
// - CYCLE_DIV    480   MCLK clocks per bubble cycle (10 us at 48 MHz)
// - TICK1_POS    240   phase at which BOUTTICKS[1] (buffer read strobe) rises
// - TICK_W       24    width in MCLK clocks of each tick pulse
// - BOOT_LEN     4106  bootloader access cycles, buffer addresses 0..4105
// - PAGE_LEN     584   user page cycles, offsets 0..583 (buffer 7168..7751)
// PORTS
// - MCLK         in   1   48 MHz clock
// - nRESET       in   1   asynchronous active-low reset
// - START        in   1   one-clock access request strobe, honoured only in IDLE
// - REQTYPE      in   3   access type requested: 3'b110 BOOT, 3'b111 USER, others rejected
// - REQPOS       in   12  absolute page position, latched on START (USER only)
// - ABORT        in   1   level; terminate access at the next cycle boundary
// - LOADREQ      out  1   buffer load request to page loader (USER only)
// - LOADPOS      out  12  latched page position presented with LOADREQ
// - LOADACK      in   1   loader done; may be held high
// - ACCTYPE      out  3   current access type; 3'b000 when idle
// - BOUTCYCLENUM out  13  cycle number; BOOT 0..BOOT_LEN-1, USER 0..PAGE_LEN-1; 8191 idle
// - ABSPOS       out  12  latched page position (0 for BOOT)
// - BOUTTICKS    out  2   [0] cycle-start tick, [1] read tick
// - BUSY         out  1   high from accepted START until return to IDLE
// - DONE         out  1   one-clock pulse on normal completion (not on abort)
// BEHAVIOUR
// - Reset values: LOADREQ=0, LOADPOS=0, ACCTYPE=000, BOUTCYCLENUM=8191, ABSPOS=0, BOUTTICKS=00, BUSY=0, DONE=0.
//   - Reset asserted mid-access returns all outputs to these values immediately.
// - States: IDLE, LOAD, RUN, FINISH.
// - IDLE
//   - START with BOOT: ACCTYPE=110, ABSPOS=0; next state RUN.
//   - START with USER: LOADPOS=ABSPOS=REQPOS, LOADREQ=1; next state LOAD.
//   - Other REQTYPE values: ignored, no state change.
//   - BUSY rises the clock after START.
// - LOAD
//   - LOADREQ held high until LOADACK is sampled high.
//   - On that clock: LOADREQ drops, ACCTYPE=111, next state RUN.
//   - ABORT in LOAD: drop LOADREQ and go to IDLE. No DONE.
// - RUN
//   - Phase counter 0..CYCLE_DIV-1 (9-bit), cleared on RUN entry. First cycle is number 0 at phase 0.
//   - BOUTCYCLENUM changes only at phase 0 and is stable through the whole cycle.
//     - Setup before the TICK1_POS edge is therefore >= TICK1_POS clocks.
//   - BOUTTICKS[0] high for phases 0..TICK_W-1.
//   - BOUTTICKS[1] high for phases TICK1_POS..TICK1_POS+TICK_W-1.
//   - Both ticks are registered outputs; no combinational glitches.
//   - At phase CYCLE_DIV-1 of the last cycle (BOOT_LEN-1 or PAGE_LEN-1): next state FINISH.
//   - Otherwise the cycle number increments at that phase.
//   - Cycle counter is 13-bit and never wraps; the compare is exact equality.
//   - ABORT sampled in RUN takes effect at phase CYCLE_DIV-1 of the current cycle.
//     - The current read tick always completes; next state IDLE, no DONE.
//   - START in any non-IDLE state is ignored.
// - FINISH (one clock)
//   - DONE=1; ACCTYPE=000, BOUTCYCLENUM=8191, BOUTTICKS=00 on the next clock.
//   - Next state IDLE; BUSY=0 from the IDLE clock.
// - Simultaneous START and ABORT in IDLE: START wins (ABORT is meaningless in IDLE).
// - Parameter sanity, checked in simulation only:
//   - TICK_W <= TICK1_POS
//   - TICK1_POS+TICK_W <= CYCLE_DIV-1
// STRUCTURE
// - Shared package holds:
//   - access type codes ACC_IDLE=000, ACC_BOOT=110, ACC_USER=111
//   - BOUT_IDLE_ADDR=8191
//   - BOOT_LEN and PAGE_LEN defaults
//   - state encoding
// - One sub-module, bubble_tick_gen: phase counter plus both tick pulses; outputs cycle_end and phase0.
// - The FSM and cycle counter stay in the top module.
// TESTING
// - Reset: nRESET low mid-RUN -> next sample shows ACCTYPE=000, BOUTCYCLENUM=8191, BOUTTICKS=00, BUSY=0.
// - BOOT access: START, REQTYPE=110 -> 4106 BOUTTICKS[1] pulses, 480 clocks apart.
//   - Cycle numbers 0..4105 in order, each stable across its tick.
//   - DONE exactly once, then BOUTCYCLENUM=8191.
// - USER access: START, REQTYPE=111, REQPOS=12'h1A3 -> LOADREQ=1, LOADPOS=1A3.
//   - LOADACK after 100 clocks -> LOADREQ drops, 584 cycles 0..583, ABSPOS=1A3, DONE.
// - ABORT at phase 300 of cycle 10 (BOOT) -> cycle 10 tick1 completes, no cycle 11, IDLE, DONE never pulses.
// - ABORT during LOAD -> LOADREQ falls next clock, IDLE, no ticks emitted.
// - START with REQTYPE=010, and START while BUSY -> ignored; outputs and state unchanged.

Source files
------------

// File: rtl/bubble_output_sequencer_pkg.sv
// Shared definitions for the bubble output sequencer slice.
// Holds access type codes, the idle cycle-number value, default timing and
// length parameters, the FSM state encoding and a phase window helper.
package bubble_output_sequencer_pkg;

    // Access type codes as seen on ACCTYPE / REQTYPE
    localparam logic [2:0] ACC_IDLE = 3'b000;
    localparam logic [2:0] ACC_BOOT = 3'b110;
    localparam logic [2:0] ACC_USER = 3'b111;

    // BOUTCYCLENUM value presented while no access is running
    localparam logic [12:0] BOUT_IDLE_ADDR = 13'd8191;

    // Default timing (48 MHz MCLK, 10 us bubble cycle) and access lengths
    localparam int unsigned CYCLE_DIV_DEF = 480;
    localparam int unsigned TICK1_POS_DEF = 240;
    localparam int unsigned TICK_W_DEF    = 24;
    localparam int unsigned BOOT_LEN_DEF  = 4106;
    localparam int unsigned PAGE_LEN_DEF  = 584;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_RUN    = 2'b10,
        ST_FINISH = 2'b11
    } state_e;

    // True when ph lies in [lo, lo+w); written as a difference so the
    // upper bound cannot overflow the 9-bit phase width.
    function automatic logic in_window(input logic [8:0] ph,
                                       input logic [8:0] lo,
                                       input logic [8:0] w);
        return (ph >= lo) && ((ph - lo) < w);
    endfunction

endpackage

// File: rtl/bubble_output_sequencer_if.sv
// Access/loader/buffer signal bundle of the bubble output sequencer.
//   master : front end + page loader side (drives requests and LOADACK)
//   slave  : the sequencer itself (drives LOADREQ and the buffer read side)
interface bubble_output_sequencer_if;
    logic        START;
    logic [2:0]  REQTYPE;
    logic [11:0] REQPOS;
    logic        ABORT;
    logic        LOADREQ;
    logic [11:0] LOADPOS;
    logic        LOADACK;
    logic [2:0]  ACCTYPE;
    logic [12:0] BOUTCYCLENUM;
    logic [11:0] ABSPOS;
    logic [1:0]  BOUTTICKS;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START, REQTYPE, REQPOS, ABORT, LOADACK,
        input  LOADREQ, LOADPOS, ACCTYPE, BOUTCYCLENUM, ABSPOS, BOUTTICKS, BUSY, DONE
    );

    modport slave (
        input  START, REQTYPE, REQPOS, ABORT, LOADACK,
        output LOADREQ, LOADPOS, ACCTYPE, BOUTCYCLENUM, ABSPOS, BOUTTICKS, BUSY, DONE
    );
endinterface

// File: rtl/bubble_output_sequencer_tick_gen.sv
// bubble_tick_gen: phase counter for one bubble cycle plus the two registered
// tick pulses.
//   MCLK, nRESET : clock, asynchronous active-low reset
//   run_now      : sequencer is in RUN this clock
//   run_next     : sequencer will be in RUN next clock
//   ticks        : [0] cycle-start tick, [1] read tick (registered)
//   cycle_end    : phase is CYCLE_DIV-1 while running
//   phase0       : phase is 0 while running
module bubble_tick_gen
    import bubble_output_sequencer_pkg::*;
#(
    parameter int unsigned CYCLE_DIV = CYCLE_DIV_DEF,
    parameter int unsigned TICK1_POS = TICK1_POS_DEF,
    parameter int unsigned TICK_W    = TICK_W_DEF
) (
    input  logic       MCLK,
    input  logic       nRESET,
    input  logic       run_now,
    input  logic       run_next,
    output logic [1:0] ticks,
    output logic       cycle_end,
    output logic       phase0
);

    localparam logic [8:0] PH_LAST  = 9'(CYCLE_DIV - 1);
    localparam logic [8:0] T1_START = 9'(TICK1_POS);
    localparam logic [8:0] T_WIDTH  = 9'(TICK_W);

    if (TICK_W > TICK1_POS) begin : g_chk_tick_w
        $error("bubble_tick_gen: TICK_W must not exceed TICK1_POS");
    end
    if (TICK1_POS + TICK_W > CYCLE_DIV - 1) begin : g_chk_tick1_end
        $error("bubble_tick_gen: read tick must end before the last phase");
    end

    logic [8:0] phase_r;
    logic [8:0] phase_next_s;
    logic [1:0] ticks_r;
    logic [1:0] ticks_next_s;

    // Next phase and tick values; ticks are decoded from the next phase so
    // the registered pulse lines up exactly with the phase it belongs to.
    always_comb begin
        phase_next_s = 9'd0;
        ticks_next_s = 2'b00;
        if (run_next && run_now && (phase_r != PH_LAST)) begin
            phase_next_s = phase_r + 9'd1;
        end else begin
            phase_next_s = 9'd0;
        end
        if (run_next) begin
            ticks_next_s[0] = in_window(phase_next_s, 9'd0, T_WIDTH);
            ticks_next_s[1] = in_window(phase_next_s, T1_START, T_WIDTH);
        end else begin
            ticks_next_s = 2'b00;
        end
    end

    // Phase counter and tick output registers
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            phase_r <= 9'd0;
            ticks_r <= 2'b00;
        end else begin
            phase_r <= phase_next_s;
            ticks_r <= ticks_next_s;
        end
    end

    assign ticks     = ticks_r;
    assign cycle_end = run_now && (phase_r == PH_LAST);
    assign phase0    = run_now && (phase_r == 9'd0);

endmodule

// File: rtl/bubble_output_sequencer.sv
// bubble_output_sequencer: drives the bubble buffer read side for one access
// (bootloader stream or one user page), requesting a page load first for
// user accesses.
//   MCLK, nRESET : 48 MHz clock, asynchronous active-low reset
//   bus (slave)  : START/REQTYPE/REQPOS/ABORT from the front end,
//                  LOADREQ/LOADPOS/LOADACK with the page loader,
//                  ACCTYPE/BOUTCYCLENUM/ABSPOS/BOUTTICKS to the buffer,
//                  BUSY/DONE status
module bubble_output_sequencer
    import bubble_output_sequencer_pkg::*;
#(
    parameter int unsigned CYCLE_DIV = CYCLE_DIV_DEF,
    parameter int unsigned TICK1_POS = TICK1_POS_DEF,
    parameter int unsigned TICK_W    = TICK_W_DEF,
    parameter int unsigned BOOT_LEN  = BOOT_LEN_DEF,
    parameter int unsigned PAGE_LEN  = PAGE_LEN_DEF
) (
    input  logic                         MCLK,
    input  logic                         nRESET,
    bubble_output_sequencer_if.slave     bus
);

    localparam logic [12:0] BOOT_LAST = 13'(BOOT_LEN - 1);
    localparam logic [12:0] PAGE_LAST = 13'(PAGE_LEN - 1);

    state_e      state_r;
    state_e      next_state_s;

    logic        loadreq_r,  loadreq_s;
    logic [11:0] loadpos_r,  loadpos_s;
    logic [2:0]  acctype_r,  acctype_s;
    logic [12:0] cycnum_r,   cycnum_s;
    logic [11:0] abspos_r,   abspos_s;
    logic        busy_r,     busy_s;
    logic        done_r,     done_s;

    logic        abort_pend_r;
    logic        last_cycle_r;
    logic        abort_s;
    logic        start_boot_s;
    logic        start_user_s;
    logic        run_now_s;
    logic        run_next_s;
    logic        cycle_end_s;
    logic        phase0_s;
    logic [12:0] last_idx_s;

    assign start_boot_s = bus.START && (bus.REQTYPE == ACC_BOOT);
    assign start_user_s = bus.START && (bus.REQTYPE == ACC_USER);
    assign run_now_s    = (state_r == ST_RUN);
    assign run_next_s   = (next_state_s == ST_RUN);
    // An abort seen at any phase of the cycle is honoured at its last phase
    assign abort_s      = bus.ABORT || abort_pend_r;
    assign last_idx_s   = (acctype_r == ACC_USER) ? PAGE_LAST : BOOT_LAST;

    bubble_tick_gen #(
        .CYCLE_DIV (CYCLE_DIV),
        .TICK1_POS (TICK1_POS),
        .TICK_W    (TICK_W)
    ) u_tick_gen (
        .MCLK      (MCLK),
        .nRESET    (nRESET),
        .run_now   (run_now_s),
        .run_next  (run_next_s),
        .ticks     (bus.BOUTTICKS),
        .cycle_end (cycle_end_s),
        .phase0    (phase0_s)
    );

    // FSM state register
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_boot_s) begin
                    next_state_s = ST_RUN;
                end else if (start_user_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.ABORT) begin
                    next_state_s = ST_IDLE;
                end else if (bus.LOADACK) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (cycle_end_s && abort_s) begin
                    next_state_s = ST_IDLE;
                end else if (cycle_end_s && last_cycle_r) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FINISH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        loadreq_s = loadreq_r;
        loadpos_s = loadpos_r;
        acctype_s = acctype_r;
        cycnum_s  = cycnum_r;
        abspos_s  = abspos_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_boot_s) begin
                    busy_s    = 1'b1;
                    acctype_s = ACC_BOOT;
                    abspos_s  = 12'd0;
                    cycnum_s  = 13'd0;
                end else if (start_user_s) begin
                    busy_s    = 1'b1;
                    loadreq_s = 1'b1;
                    loadpos_s = bus.REQPOS;
                    abspos_s  = bus.REQPOS;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.ABORT) begin
                    loadreq_s = 1'b0;
                    busy_s    = 1'b0;
                end else if (bus.LOADACK) begin
                    loadreq_s = 1'b0;
                    acctype_s = ACC_USER;
                    cycnum_s  = 13'd0;
                end else begin
                    loadreq_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (cycle_end_s && abort_s) begin
                    acctype_s = ACC_IDLE;
                    cycnum_s  = BOUT_IDLE_ADDR;
                    busy_s    = 1'b0;
                end else if (cycle_end_s && last_cycle_r) begin
                    done_s    = 1'b1;
                end else if (cycle_end_s) begin
                    cycnum_s  = cycnum_r + 13'd1;
                end else begin
                    cycnum_s  = cycnum_r;
                end
            end
            ST_FINISH: begin
                acctype_s = ACC_IDLE;
                cycnum_s  = BOUT_IDLE_ADDR;
                busy_s    = 1'b0;
                loadreq_s = 1'b0;
            end
            default: begin
                loadreq_s = 1'b0;
                acctype_s = ACC_IDLE;
                cycnum_s  = BOUT_IDLE_ADDR;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            loadreq_r <= 1'b0;
            loadpos_r <= 12'd0;
            acctype_r <= ACC_IDLE;
            cycnum_r  <= BOUT_IDLE_ADDR;
            abspos_r  <= 12'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            loadreq_r <= loadreq_s;
            loadpos_r <= loadpos_s;
            acctype_r <= acctype_s;
            cycnum_r  <= cycnum_s;
            abspos_r  <= abspos_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Pending abort; cleared at each cycle boundary and outside RUN
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            abort_pend_r <= 1'b0;
        end else if (run_now_s && !cycle_end_s) begin
            abort_pend_r <= abort_pend_r || bus.ABORT;
        end else begin
            abort_pend_r <= 1'b0;
        end
    end

    // Last-cycle flag, evaluated once per cycle at phase 0 so the wide
    // equality compare is off the cycle-end decision path.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            last_cycle_r <= 1'b0;
        end else if (!run_now_s) begin
            last_cycle_r <= 1'b0;
        end else if (phase0_s) begin
            last_cycle_r <= (cycnum_r == last_idx_s);
        end else begin
            last_cycle_r <= last_cycle_r;
        end
    end

    assign bus.LOADREQ      = loadreq_r;
    assign bus.LOADPOS      = loadpos_r;
    assign bus.ACCTYPE      = acctype_r;
    assign bus.BOUTCYCLENUM = cycnum_r;
    assign bus.ABSPOS       = abspos_r;
    assign bus.BUSY         = busy_r;
    assign bus.DONE         = done_r;

endmodule

// File: tb/tb_bubble_output_sequencer.sv
// Directed bench for bubble_output_sequencer using shortened timing
// parameters (48-clock cycles, 16-cycle boot, 8-cycle page).
module tb_bubble_output_sequencer;
    import bubble_output_sequencer_pkg::*;

    localparam int CD = 48;
    localparam int T1 = 24;
    localparam int TW = 4;
    localparam int BL = 16;
    localparam int PL = 8;

    logic MCLK   = 1'b0;
    logic nRESET = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    bubble_output_sequencer_if bus();

    bubble_output_sequencer #(
        .CYCLE_DIV (CD),
        .TICK1_POS (T1),
        .TICK_W    (TW),
        .BOOT_LEN  (BL),
        .PAGE_LEN  (PL)
    ) dut (
        .MCLK   (MCLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_acctype"}, 32'(bus.ACCTYPE), 32'(ACC_IDLE));
        chk({tag, "_cycnum"},  32'(bus.BOUTCYCLENUM), 32'd8191);
        chk({tag, "_ticks"},   32'(bus.BOUTTICKS), 32'd0);
        chk({tag, "_busy"},    32'(bus.BUSY), 32'd0);
        chk({tag, "_loadreq"}, 32'(bus.LOADREQ), 32'd0);
        chk({tag, "_done"},    32'(bus.DONE), 32'd0);
    endtask

    // Walks every phase of every cycle from phase 0 of cycle 0; optionally
    // raises ABORT for one clock at (abort_c, abort_p) and stops after that
    // cycle. Also pokes a START while busy, which must be ignored.
    task automatic run_cycles(input logic [2:0] acc, input int ncyc,
                              input int abort_c, input int abort_p);
        int   last_c = (abort_c >= 0) ? abort_c : ncyc - 1;
        int   rises  = 0;
        logic prev_t1 = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            for (int p = 0; p < CD; p++) begin
                chk("cycnum", 32'(bus.BOUTCYCLENUM), 32'(c));
                chk("tick0",  32'(bus.BOUTTICKS[0]), 32'(p < TW));
                chk("tick1",  32'(bus.BOUTTICKS[1]), 32'((p >= T1) && (p < T1 + TW)));
                chk("run_acctype", 32'(bus.ACCTYPE), 32'(acc));
                chk("run_busy", 32'(bus.BUSY), 32'd1);
                chk("run_done", 32'(bus.DONE), 32'd0);
                if (bus.BOUTTICKS[1] && !prev_t1) rises++;
                prev_t1 = bus.BOUTTICKS[1];
                bus.ABORT = (c == abort_c) && (p == abort_p);
                if (c == 3 && p == 5) begin
                    bus.START   = 1'b1;
                    bus.REQTYPE = 3'b111;
                    bus.REQPOS  = 12'hFFF;
                end else begin
                    bus.START = 1'b0;
                end
                @(negedge MCLK);
            end
        end
        chk("tick1_pulses", 32'(rises), 32'(last_c + 1));
    endtask

    // Counts any tick, DONE or busy activity over n quiet clocks
    task automatic chk_quiet(input string tag, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.BOUTTICKS !== 2'b00 || bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) act++;
            @(negedge MCLK);
        end
        chk(tag, 32'(act), 32'd0);
    endtask

    initial begin
        int drops;
        bus.START   = 1'b0;
        bus.REQTYPE = 3'b000;
        bus.REQPOS  = 12'h000;
        bus.ABORT   = 1'b0;
        bus.LOADACK = 1'b0;

        // Reset values
        repeat (3) @(negedge MCLK);
        chk_idle("reset");
        chk("reset_loadpos", 32'(bus.LOADPOS), 32'd0);
        chk("reset_abspos",  32'(bus.ABSPOS), 32'd0);
        nRESET = 1'b1;
        @(negedge MCLK);

        // Rejected request type
        bus.START = 1'b1; bus.REQTYPE = 3'b010;
        @(negedge MCLK);
        bus.START = 1'b0;
        chk_idle("reject1");
        @(negedge MCLK);
        chk_idle("reject2");

        // Full BOOT access
        bus.START = 1'b1; bus.REQTYPE = 3'b110;
        @(negedge MCLK);
        bus.START = 1'b0;
        chk("boot_abspos", 32'(bus.ABSPOS), 32'd0);
        run_cycles(3'b110, BL, -1, -1);
        chk("boot_finish_done",  32'(bus.DONE), 32'd1);
        chk("boot_finish_busy",  32'(bus.BUSY), 32'd1);
        chk("boot_finish_ticks", 32'(bus.BOUTTICKS), 32'd0);
        @(negedge MCLK);
        chk_idle("boot_end");
        chk("boot_end_loadreq_after_busy_start", 32'(bus.LOADREQ), 32'd0);

        // USER access with a delayed acknowledge
        bus.START = 1'b1; bus.REQTYPE = 3'b111; bus.REQPOS = 12'h1A3;
        @(negedge MCLK);
        bus.START = 1'b0;
        chk("user_loadreq", 32'(bus.LOADREQ), 32'd1);
        chk("user_loadpos", 32'(bus.LOADPOS), 32'h1A3);
        chk("user_abspos",  32'(bus.ABSPOS), 32'h1A3);
        chk("user_busy",    32'(bus.BUSY), 32'd1);
        chk("user_load_acctype", 32'(bus.ACCTYPE), 32'(ACC_IDLE));
        chk("user_load_cycnum",  32'(bus.BOUTCYCLENUM), 32'd8191);
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.LOADREQ !== 1'b1 || bus.BOUTTICKS !== 2'b00) drops++;
            @(negedge MCLK);
        end
        chk("user_loadreq_held", 32'(drops), 32'd0);
        bus.LOADACK = 1'b1;
        @(negedge MCLK);
        chk("user_loadreq_drop", 32'(bus.LOADREQ), 32'd0);
        run_cycles(3'b111, PL, -1, -1);
        chk("user_finish_done", 32'(bus.DONE), 32'd1);
        bus.LOADACK = 1'b0;
        @(negedge MCLK);
        chk_idle("user_end");
        chk("user_end_abspos", 32'(bus.ABSPOS), 32'h1A3);

        // BOOT access aborted mid-cycle 10
        bus.START = 1'b1; bus.REQTYPE = 3'b110;
        @(negedge MCLK);
        bus.START = 1'b0;
        run_cycles(3'b110, BL, 10, 30);
        chk_idle("abort_run_end");
        chk_quiet("abort_run_quiet", 100);

        // ABORT while waiting for the loader
        bus.START = 1'b1; bus.REQTYPE = 3'b111; bus.REQPOS = 12'h055;
        @(negedge MCLK);
        bus.START = 1'b0;
        chk("abort_load_req", 32'(bus.LOADREQ), 32'd1);
        repeat (5) @(negedge MCLK);
        bus.ABORT = 1'b1;
        @(negedge MCLK);
        bus.ABORT = 1'b0;
        chk_idle("abort_load_end");
        chk_quiet("abort_load_quiet", 60);

        // START and ABORT together in IDLE: START wins
        bus.START = 1'b1; bus.REQTYPE = 3'b110; bus.ABORT = 1'b1;
        @(negedge MCLK);
        bus.START = 1'b0; bus.ABORT = 1'b0;
        chk("sa_busy",    32'(bus.BUSY), 32'd1);
        chk("sa_acctype", 32'(bus.ACCTYPE), 32'(ACC_BOOT));
        chk("sa_cycnum",  32'(bus.BOUTCYCLENUM), 32'd0);
        chk("sa_ticks",   32'(bus.BOUTTICKS), 32'd1);
        repeat (52) @(negedge MCLK);
        chk("sa_cycnum_later", 32'(bus.BOUTCYCLENUM), 32'd1);
        chk("sa_tick0_later",  32'(bus.BOUTTICKS), 32'd0);

        // Asynchronous reset in the middle of RUN
        #2 nRESET = 1'b0;
        @(negedge MCLK);
        chk_idle("midrun_reset");
        chk("midrun_reset_loadpos", 32'(bus.LOADPOS), 32'd0);
        nRESET = 1'b1;
        @(negedge MCLK);
        bus.START = 1'b1; bus.REQTYPE = 3'b110;
        @(negedge MCLK);
        bus.START = 1'b0;
        chk("post_reset_acctype", 32'(bus.ACCTYPE), 32'(ACC_BOOT));
        chk("post_reset_cycnum",  32'(bus.BOUTCYCLENUM), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
